// File: rtl/candy_avb_desc_ram.sv
// Dual-port Avalon-MM descriptor RAM with a pipelined read path (latency 1 or 2)
// and a post-reset clear engine that fills the array before it accepts requests.
module candy_avb_desc_ram #(
    parameter int                      DATA_WIDTH     = 32,
    parameter int                      ADDR_WIDTH     = 11,
    parameter int                      READ_LATENCY   = 1,
    parameter int                      CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE    = {DATA_WIDTH{1'b0}}
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clken,
    input  logic [ADDR_WIDTH-1:0]     s1_address,
    input  logic                      s1_chipselect,
    input  logic                      s1_read,
    input  logic                      s1_write,
    input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
    input  logic [DATA_WIDTH-1:0]     s1_writedata,
    output logic [DATA_WIDTH-1:0]     s1_readdata,
    output logic                      s1_readdatavalid,
    output logic                      s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]     s2_address,
    input  logic                      s2_chipselect,
    input  logic                      s2_read,
    input  logic                      s2_write,
    input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
    input  logic [DATA_WIDTH-1:0]     s2_writedata,
    output logic [DATA_WIDTH-1:0]     s2_readdata,
    output logic                      s2_readdatavalid,
    output logic                      s2_waitrequest,
    output logic                      init_done
);

    localparam int                DEPTH    = 2**ADDR_WIDTH;
    localparam int                NB       = DATA_WIDTH/8;
    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH+1)'(DEPTH-1);
    localparam logic [ADDR_WIDTH:0] CLR_ONE  = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH:0]     clr_addr_q;
    logic                    init_done_q;
    logic                    wait_s;
    logic                    clear_en_s;
    logic [1:0]              wr_acc_s;
    logic [1:0]              rd_acc_s;
    logic [NB-1:0]           we_s    [2];
    logic [ADDR_WIDTH-1:0]   waddr_s [2];
    logic [DATA_WIDTH-1:0]   wdata_s [2];
    logic [ADDR_WIDTH-1:0]   raddr_s [2];
    logic [DATA_WIDTH-1:0]   rdata_s [2];
    logic                    rvalid_s[2];
    logic [DATA_WIDTH-1:0]   mem_q   [DEPTH];

    assign wait_s      = ~init_done_q | ~clken;
    assign clear_en_s  = (state_q == ST_CLEAR) & clken & reset_n;
    // A reset edge never commits a user request, even if init_done is still high.
    assign wr_acc_s[0] = s1_chipselect & s1_write & ~wait_s & reset_n;
    assign wr_acc_s[1] = s2_chipselect & s2_write & ~wait_s & reset_n;
    assign rd_acc_s[0] = s1_chipselect & s1_read & ~s1_write & ~wait_s & reset_n;
    assign rd_acc_s[1] = s2_chipselect & s2_read & ~s2_write & ~wait_s & reset_n;
    assign raddr_s[0]  = s1_address;
    assign raddr_s[1]  = s2_address;

    // Init sequencer: RESET -> CLEAR (optional zero-fill) -> RUN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_RESET;
            clr_addr_q  <= {(ADDR_WIDTH+1){1'b0}};
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (CLEAR_ON_RESET != 0) begin
                        state_q <= ST_CLEAR;
                    end else begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clken) begin
                        clr_addr_q <= clr_addr_q + CLR_ONE;
                        if (clr_addr_q == CLR_LAST) begin
                            state_q     <= ST_RUN;
                            init_done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN:  init_done_q <= 1'b1;
                default: state_q     <= ST_RESET;
            endcase
        end
    end

    // Array write-port selection; the clear engine borrows port 1.
    always_comb begin
        waddr_s[0] = s1_address;
        wdata_s[0] = s1_writedata;
        waddr_s[1] = s2_address;
        wdata_s[1] = s2_writedata;
        we_s[1]    = wr_acc_s[1] ? s2_byteenable : {NB{1'b0}};
        if (clear_en_s) begin
            we_s[0]    = {NB{1'b1}};
            waddr_s[0] = clr_addr_q[ADDR_WIDTH-1:0];
            wdata_s[0] = CLEAR_VALUE;
        end else if (wr_acc_s[0]) begin
            we_s[0] = s1_byteenable;
        end else begin
            we_s[0] = {NB{1'b0}};
        end
    end

    // Storage array: on a shared address port 1 owns every lane it enables.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we_s[1][b] && !(we_s[0][b] && (waddr_s[0] == waddr_s[1]))) begin
                mem_q[waddr_s[1]][b*8 +: 8] <= wdata_s[1][b*8 +: 8];
            end
            if (we_s[0][b]) begin
                mem_q[waddr_s[0]][b*8 +: 8] <= wdata_s[0][b*8 +: 8];
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_WIDTH-1:0] st1_data_q;
        logic                  st1_valid_q;

        // First read stage: array reads see pre-write contents on a collision.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                st1_data_q  <= {DATA_WIDTH{1'b0}};
                st1_valid_q <= 1'b0;
            end else if (clken) begin
                st1_valid_q <= rd_acc_s[p];
                if (rd_acc_s[p]) begin
                    st1_data_q <= mem_q[raddr_s[p]];
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] out_data_q;
            logic                  out_valid_q;

            // Extra output register stage; data holds between valid beats.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    out_data_q  <= {DATA_WIDTH{1'b0}};
                    out_valid_q <= 1'b0;
                end else if (clken) begin
                    out_valid_q <= st1_valid_q;
                    if (st1_valid_q) begin
                        out_data_q <= st1_data_q;
                    end
                end
            end

            assign rdata_s[p]  = out_data_q;
            assign rvalid_s[p] = out_valid_q;
        end else begin : g_lat1
            assign rdata_s[p]  = st1_data_q;
            assign rvalid_s[p] = st1_valid_q;
        end
    end

    assign s1_readdata      = rdata_s[0];
    assign s1_readdatavalid = rvalid_s[0];
    assign s1_waitrequest   = wait_s;
    assign s2_readdata      = rdata_s[1];
    assign s2_readdatavalid = rvalid_s[1];
    assign s2_waitrequest   = wait_s;
    assign init_done        = init_done_q;

endmodule
